// File: rtl/passcode_register_bank.sv
// passcode_register_bank: collects switch digits, stores a system code, compares entries and locks out after repeated failures
module passcode_register_bank #(
    parameter int DIGIT_W    = 2,
    parameter int NUM_DIGITS = 4,
    parameter int MAX_FAILS  = 3
) (
    input  logic               clk,
    input  logic               system_reset,
    input  logic               input_value,
    input  logic               store_value,
    input  logic               compare,
    input  logic               input_reset,
    input  logic [DIGIT_W-1:0] bits,
    input  logic               show_stored,
    output logic [3:0]         reg0,
    output logic [3:0]         reg1,
    output logic [3:0]         reg2,
    output logic [3:0]         reg3,
    output logic [2:0]         digit_count,
    output logic               entry_full,
    output logic               stored_valid,
    output logic               correct_password,
    output logic               incorrect_password,
    output logic               lockout
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam logic [2:0]    ND = 3'(NUM_DIGITS);
    localparam logic [FW-1:0] MF = FW'(MAX_FAILS);

    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] r_entry, r_code, w_disp;
    logic [2:0]    r_cnt;
    logic [FW-1:0] r_fails;
    logic          r_in_q, r_st_q, r_cmp_q;
    logic          r_valid, r_ok, r_bad, r_lock;
    logic          w_in_e, w_st_e, w_cmp_e, w_full, w_match;

    assign w_in_e  = input_value & ~r_in_q;
    assign w_st_e  = store_value & ~r_st_q;
    assign w_cmp_e = compare & ~r_cmp_q;
    assign w_full  = (r_cnt == ND);
    assign w_match = w_full && (r_entry == r_code);

    always_ff @(posedge clk or posedge system_reset) begin
        if (system_reset) begin
            r_entry <= '0;
            r_code  <= '0;
            r_cnt   <= '0;
            r_fails <= '0;
            r_in_q  <= 1'b0;
            r_st_q  <= 1'b0;
            r_cmp_q <= 1'b0;
            r_valid <= 1'b0;
            r_ok    <= 1'b0;
            r_bad   <= 1'b0;
            r_lock  <= 1'b0;
        end else begin
            r_in_q  <= input_value;
            r_st_q  <= store_value;
            r_cmp_q <= compare;
            // one action per cycle; a winning edge that turns out to be a no-op still drops the others
            if (input_reset) begin
                r_entry <= '0;
                r_cnt   <= '0;
                r_ok    <= 1'b0;
                r_bad   <= 1'b0;
            end else if (!r_lock && w_st_e) begin
                if (w_full) begin
                    r_code  <= r_entry;
                    r_valid <= 1'b1;
                    r_entry <= '0;
                    r_cnt   <= '0;
                    r_fails <= '0;
                end
            end else if (!r_lock && w_cmp_e) begin
                if (r_valid) begin
                    r_entry <= '0;
                    r_cnt   <= '0;
                    r_ok    <= w_match;
                    r_bad   <= !w_match;
                    if (w_match) begin
                        r_fails <= '0;
                    end else begin
                        if (r_fails != MF) r_fails <= r_fails + 1'b1;
                        if (r_fails == MF - 1'b1) r_lock <= 1'b1;
                    end
                end
            end else if (!r_lock && w_in_e) begin
                r_ok  <= 1'b0;
                r_bad <= 1'b0;
                if (!w_full) begin
                    r_entry[r_cnt[IW-1:0]] <= bits;
                    r_cnt <= r_cnt + 3'd1;
                end
            end
        end
    end

    // r_code only ever holds zeros until a code is committed
    assign w_disp = show_stored ? r_code : r_entry;
    assign reg0 = 4'(w_disp[0]);
    assign reg1 = 4'(w_disp[1]);
    assign reg2 = 4'(w_disp[2]);
    assign reg3 = 4'(w_disp[3]);
    assign digit_count        = r_cnt;
    assign entry_full         = w_full;
    assign stored_valid       = r_valid;
    assign correct_password   = r_ok;
    assign incorrect_password = r_bad;
    assign lockout            = r_lock;
endmodule

// File: tb/tb_passcode_register_bank.sv
// tb_passcode_register_bank: randomized and directed checks against a queue-based passcode model
module tb_passcode_register_bank;
    logic clk = 0, system_reset = 1, input_value = 0, store_value = 0, compare = 0;
    logic input_reset = 0, show_stored = 0;
    logic [1:0] bits = 0;
    logic [3:0] reg0, reg1, reg2, reg3;
    logic [2:0] digit_count;
    logic entry_full, stored_valid, correct_password, incorrect_password, lockout;
    int total = 0, passed = 0;

    int m_entry[$], m_code[$];
    bit m_valid, m_ok, m_bad, m_lock;
    int m_fails;

    passcode_register_bank dut (
        .clk(clk), .system_reset(system_reset), .input_value(input_value),
        .store_value(store_value), .compare(compare), .input_reset(input_reset),
        .bits(bits), .show_stored(show_stored), .reg0(reg0), .reg1(reg1), .reg2(reg2),
        .reg3(reg3), .digit_count(digit_count), .entry_full(entry_full),
        .stored_valid(stored_valid), .correct_password(correct_password),
        .incorrect_password(incorrect_password), .lockout(lockout)
    );

    always #5 clk = ~clk;

    function automatic void m_reset();
        m_entry = {};
        m_code = {};
        m_valid = 0; m_ok = 0; m_bad = 0; m_lock = 0; m_fails = 0;
    endfunction

    function automatic void m_ireset();
        m_entry = {};
        m_ok = 0; m_bad = 0;
    endfunction

    function automatic void m_in(int d);
        if (m_lock) return;
        m_ok = 0; m_bad = 0;
        if (m_entry.size() < 4) m_entry.push_back(d);
    endfunction

    function automatic void m_st();
        if (m_lock || m_entry.size() != 4) return;
        m_code = m_entry;
        m_valid = 1;
        m_entry = {};
        m_fails = 0;
    endfunction

    function automatic void m_cmp();
        bit match;
        if (m_lock || !m_valid) return;
        match = (m_entry.size() == 4);
        for (int i = 0; i < 4 && match; i++) if (m_entry[i] != m_code[i]) match = 0;
        m_entry = {};
        if (match) begin
            m_ok = 1; m_bad = 0; m_fails = 0;
        end else begin
            m_ok = 0; m_bad = 1;
            if (m_fails < 3) m_fails++;
            if (m_fails >= 3) m_lock = 1;
        end
    endfunction

    function automatic logic [23:0] exp_vec();
        logic [15:0] d = '0;
        for (int i = 0; i < 4; i++) begin
            int v;
            v = show_stored ? (m_valid ? m_code[i] : 0) : (i < m_entry.size() ? m_entry[i] : 0);
            d[15-4*i -: 4] = 4'(v);
        end
        return {d, 3'(m_entry.size()), m_entry.size() == 4, m_valid, m_ok, m_bad, m_lock};
    endfunction

    function automatic logic [23:0] act_vec();
        return {reg0, reg1, reg2, reg3, digit_count, entry_full, stored_valid,
                correct_password, incorrect_password, lockout};
    endfunction

    task automatic op(bit ir, bit st, bit cmp, bit inp, logic [1:0] d);
        @(negedge clk);
        input_reset = ir; store_value = st; compare = cmp; input_value = inp; bits = d;
        if (ir) m_ireset();
        else if (st) m_st();
        else if (cmp) m_cmp();
        else if (inp) m_in(d);
        @(negedge clk);
        input_reset = 0; store_value = 0; compare = 0; input_value = 0;
    endtask

    task automatic pulse5(logic [1:0] d);
        @(negedge clk);
        input_value = 1; bits = d;
        m_in(d);
        repeat (5) @(negedge clk);
        input_value = 0;
    endtask

    task automatic sys_reset();
        @(negedge clk);
        system_reset = 1;
        m_reset();
        @(negedge clk);
        system_reset = 0;
    endtask

    task automatic test_reset();
        #1;
        for (int s = 0; s < 2; s++) begin
            show_stored = 1'(s); #1;
            total++;
            if (act_vec() !== 24'h0) $display("FAIL reset_show%0d got=%h want=%h", s, act_vec(), 24'h0);
            else passed++;
        end
        show_stored = 0;
        input_value = 1; bits = 2;
        @(negedge clk);
        system_reset = 0;
        m_reset();
        m_in(2);
        repeat (3) @(negedge clk);
        input_value = 0;
        total++;
        if (act_vec() !== exp_vec()) $display("FAIL held_across_reset got=%h want=%h", act_vec(), exp_vec());
        else passed++;
        sys_reset();
    endtask

    task automatic test_entry();
        logic [1:0] ds [5] = '{1, 2, 3, 0, 3};
        for (int i = 0; i < 5; i++) begin
            pulse5(ds[i]);
            total++;
            if (act_vec() !== exp_vec()) $display("FAIL entry_%0d got=%h want=%h", i, act_vec(), exp_vec());
            else passed++;
        end
    endtask

    task automatic test_store();
        op(0, 1, 0, 0, 0);
        for (int s = 0; s < 2; s++) begin
            show_stored = 1'(s); #1;
            total++;
            if (act_vec() !== exp_vec()) $display("FAIL store_show%0d got=%h want=%h", s, act_vec(), exp_vec());
            else passed++;
        end
        show_stored = 0;
    endtask

    task automatic test_compare_ok();
        logic [1:0] ds [4] = '{1, 2, 3, 0};
        for (int i = 0; i < 4; i++) op(0, 0, 0, 1, ds[i]);
        op(0, 0, 1, 0, 0);
        total++;
        if (act_vec() !== exp_vec() || correct_password !== 1'b1)
            $display("FAIL compare_match got=%h want=%h", act_vec(), exp_vec());
        else passed++;
        op(0, 0, 0, 1, 1);
        total++;
        if (act_vec() !== exp_vec()) $display("FAIL input_clears_ok got=%h want=%h", act_vec(), exp_vec());
        else passed++;
    endtask

    task automatic test_lockout();
        int seq [3][4] = '{'{1, 2, 3, 1}, '{0, 0, 0, 0}, '{1, 2, 0, 0}};
        int len [3] = '{4, 4, 2};
        op(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < len[k]; i++) op(0, 0, 0, 1, 2'(seq[k][i]));
            op(0, 0, 1, 0, 0);
            total++;
            if (act_vec() !== exp_vec()) $display("FAIL mismatch_%0d got=%h want=%h", k, act_vec(), exp_vec());
            else passed++;
        end
        op(0, 0, 0, 1, 1);
        op(0, 1, 0, 0, 0);
        op(0, 0, 1, 0, 0);
        total++;
        if (act_vec() !== exp_vec()) $display("FAIL locked_ignores got=%h want=%h", act_vec(), exp_vec());
        else passed++;
        sys_reset();
        total++;
        if (act_vec() !== 24'h0) $display("FAIL lockout_reset got=%h want=%h", act_vec(), 24'h0);
        else passed++;
    endtask

    task automatic test_priority();
        logic [1:0] ds [4] = '{1, 2, 3, 0};
        for (int i = 0; i < 4; i++) op(0, 0, 0, 1, ds[i]);
        op(0, 1, 0, 1, 3);
        total++;
        if (act_vec() !== exp_vec()) $display("FAIL store_over_input got=%h want=%h", act_vec(), exp_vec());
        else passed++;
        for (int i = 0; i < 4; i++) op(0, 0, 0, 1, 1);
        op(0, 0, 1, 0, 0);
        op(0, 0, 0, 1, 1);
        op(0, 0, 0, 1, 2);
        op(1, 0, 1, 0, 0);
        total++;
        if (act_vec() !== exp_vec()) $display("FAIL ireset_over_compare got=%h want=%h", act_vec(), exp_vec());
        else passed++;
        op(0, 0, 0, 1, 0);
        op(0, 0, 1, 0, 0);
        total++;
        if (act_vec() !== exp_vec()) $display("FAIL fail_count_kept got=%h want=%h", act_vec(), exp_vec());
        else passed++;
        op(0, 0, 0, 1, 0);
        op(0, 0, 1, 0, 0);
        total++;
        if (act_vec() !== exp_vec()) $display("FAIL third_fail_locks got=%h want=%h", act_vec(), exp_vec());
        else passed++;
        sys_reset();
    endtask

    task automatic test_unstored_async();
        op(0, 0, 0, 1, 1);
        op(0, 0, 0, 1, 2);
        op(0, 0, 1, 0, 0);
        total++;
        if (act_vec() !== exp_vec()) $display("FAIL compare_unstored got=%h want=%h", act_vec(), exp_vec());
        else passed++;
        @(negedge clk);
        system_reset = 1;
        m_reset();
        #1;
        total++;
        if (act_vec() !== 24'h0) $display("FAIL async_reset got=%h want=%h", act_vec(), 24'h0);
        else passed++;
        @(negedge clk);
        system_reset = 0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 19);
            if (m_lock && r < 3) sys_reset();
            else if (r < 9) op(0, 0, 0, 1, 2'($urandom_range(0, 3)));
            else if (r < 11) op(0, 1, 0, 0, 0);
            else if (r < 13) op(0, 0, 1, 0, 0);
            else if (r == 13) op(1, 0, 0, 0, 0);
            else if (r < 17) op($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                2'($urandom_range(0, 3)));
            else begin
                op(1, 0, 0, 0, 0);
                for (int i = 0; i < 4; i++) op(0, 0, 0, 1, m_valid ? 2'(m_code[i]) : 2'($urandom_range(0, 3)));
                op(0, 0, 1, 0, 0);
            end
            show_stored = 1'($urandom_range(0, 1)); #1;
            total++;
            if (act_vec() !== exp_vec()) $display("FAIL random_%0d got=%h want=%h", n, act_vec(), exp_vec());
            else passed++;
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_entry();
        test_store();
        test_compare_ok();
        test_lockout();
        test_priority();
        test_unstored_async();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
